// File: rtl/nibble_serial_add_ctrl.sv
// nibble_serial_add_ctrl: WIDTH-bit adder built from one 4-bit carry-lookahead
// adder, which is used once per clock, starting with the least-significant
// nibble.
// A Start pulse latches the operands. Busy is high while the nibbles are being
// added, and Done pulses for one cycle once S, Cout and Overflow are valid.
// Optional feature macro: NIBBLE_ADD_SUB_EN adds a Sub input that selects A-B.
//
// state | meaning
// IDLE  | waiting for Start
// RUN   | one nibble per clock through the shared CLA
// DONE  | one-cycle result-valid pulse; Start here begins the next op at once

// 4-bit carry-lookahead adder; carries come from generate/propagate terms.
module carry_lookahead_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  // Lookahead carries computed directly from g/p, so no carry ripples through.
  always_comb begin
    g    = a & b;
    p    = a ^ b;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & cin);
    sum  = p ^ c[3:0];
    cout = c[4];
  end

endmodule

module nibble_serial_add_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
`ifdef NIBBLE_ADD_SUB_EN
  input  logic             Sub,
`endif
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             Overflow
);

  localparam int NIBBLES = WIDTH / 4;
  localparam int IDXW    = $clog2(NIBBLES);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             carry;
  logic [IDXW-1:0]  idx;

  logic [WIDTH-1:0] b_load;
  logic             c_load;
  logic [3:0]       nib_a;
  logic [3:0]       nib_b;
  logic [3:0]       cla_sum;
  logic             cla_cout;
  logic             last_nib;
  logic             accept;

  // The stored addend is the effective one (already inverted for subtract), so
  // both the datapath and the overflow test see the operand the adder uses.
  always_comb begin
`ifdef NIBBLE_ADD_SUB_EN
    b_load = Sub ? ~B : B;
    c_load = Sub ? 1'b1 : Cin;
`else
    b_load = B;
    c_load = Cin;
`endif
  end

  // Select the current nibble for the shared adder, and decode when to finish
  // and when a new request is taken.
  always_comb begin
    nib_a    = a_reg[4*idx +: 4];
    nib_b    = b_reg[4*idx +: 4];
    last_nib = (idx == IDXW'(NIBBLES - 1));
    accept   = Start && ((state == IDLE) || (state == DONE));
  end

  carry_lookahead_4bit u_cla (
    .a    (nib_a),
    .b    (nib_b),
    .cin  (carry),
    .sum  (cla_sum),
    .cout (cla_cout)
  );

  // Sequencer, operand registers and registered result/status outputs.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state    <= IDLE;
      a_reg    <= '0;
      b_reg    <= '0;
      carry    <= 1'b0;
      idx      <= '0;
      S        <= '0;
      Cout     <= 1'b0;
      Overflow <= 1'b0;
      Busy     <= 1'b0;
      Done     <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          Done <= 1'b0;
          if (accept) begin
            a_reg <= A;
            b_reg <= b_load;
            carry <= c_load;
            idx   <= '0;
            Busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          S[4*idx +: 4] <= cla_sum;
          carry         <= cla_cout;
          idx           <= idx + 1'b1;
          if (last_nib) begin
            Cout     <= cla_cout;
            Overflow <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                        (cla_sum[3] != a_reg[WIDTH-1]);
            Busy     <= 1'b0;
            Done     <= 1'b1;
            state    <= DONE;
          end
        end
        default: begin
          Busy  <= 1'b0;
          Done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Testbench for nibble_serial_add_ctrl with WIDTH=16: a table of directed
// vectors, hand-written sequences for back-to-back operation, Start during
// RUN and reset mid-operation, and randomized operations checked against an
// arithmetic reference model.
module tb_nibble_serial_add_ctrl;

  localparam int W   = 16;
  localparam int NIB = W / 4;

  logic         Clk;
  logic         Rst_n;
  logic         Start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Cin;
  logic         Sub;
  logic         Busy;
  logic         Done;
  logic [W-1:0] S;
  logic         Cout;
  logic         Overflow;

  int n_cmp = 0;
  int n_err = 0;

  nibble_serial_add_ctrl #(.WIDTH(W)) dut (
    .Clk      (Clk),
    .Rst_n    (Rst_n),
    .Start    (Start),
    .A        (A),
    .B        (B),
    .Cin      (Cin),
`ifdef NIBBLE_ADD_SUB_EN
    .Sub      (Sub),
`endif
    .Busy     (Busy),
    .Done     (Done),
    .S        (S),
    .Cout     (Cout),
    .Overflow (Overflow)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] s;
    logic         cout;
    logic         ovf;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain WIDTH+1-bit arithmetic on the effective operands.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic cin, input logic sub,
                                output logic [W-1:0] s, output logic co, output logic ov);
    logic [W-1:0] be;
    logic [W:0]   t;
    logic         c;
    be = sub ? ~b : b;
    c  = sub ? 1'b1 : cin;
    t  = {1'b0, a} + {1'b0, be} + {{W{1'b0}}, c};
    s  = t[W-1:0];
    co = t[W];
    ov = (a[W-1] == be[W-1]) && (s[W-1] != a[W-1]);
  endfunction

  // Issue one request. On return Done has just been sampled high (or the
  // cycle budget ran out). lat counts edges after the accepting edge, busy
  // counts Busy samples taken before Done.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                       input logic sub, output int lat, output int busy);
    @(negedge Clk);
    A = a; B = b; Cin = cin; Sub = sub; Start = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
    A = W'($urandom); B = W'($urandom); Cin = 1'($urandom); Sub = 1'($urandom);
    lat  = 0;
    busy = 0;
    while (!Done && lat < 20) begin
      if (Busy) busy++;
      @(posedge Clk); #1;
      lat++;
    end
  endtask

  task automatic run_and_check(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic cin, input logic sub,
                               input logic [W-1:0] es, input logic ec, input logic eo);
    int lat, busy;
    do_op(a, b, cin, sub, lat, busy);
    chk({tag, ".lat"}, 32'(lat), 32'(NIB));
    chk({tag, ".busy"}, 32'(busy), 32'(NIB));
    chk({tag, ".S"}, 32'(S), 32'(es));
    chk({tag, ".Cout"}, 32'(Cout), 32'(ec));
    chk({tag, ".Ovf"}, 32'(Overflow), 32'(eo));
  endtask

  initial begin
    int lat, busy, dcnt;
    logic [W-1:0] es, sdone;
    logic ec, eo, rs;
    logic [W-1:0] ra, rb;
    logic rc;

    vecs.push_back('{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0});
    vecs.push_back('{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0});
    vecs.push_back('{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1});
    vecs.push_back('{16'h1234, 16'h1111, 1'b1, 1'b0, 16'h2346, 1'b0, 1'b0});
    vecs.push_back('{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1});
    vecs.push_back('{16'h0F0F, 16'h00F1, 1'b1, 1'b0, 16'h1001, 1'b0, 1'b0});
`ifdef NIBBLE_ADD_SUB_EN
    vecs.push_back('{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0});
    vecs.push_back('{16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1});
    vecs.push_back('{16'h0009, 16'h0009, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0});
`endif

    Rst_n = 1'b0; Start = 1'b0; A = '0; B = '0; Cin = 1'b0; Sub = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    chk("rst.S", 32'(S), 32'h0);
    chk("rst.Busy", 32'(Busy), 32'h0);
    chk("rst.Done", 32'(Done), 32'h0);
    chk("rst.Cout", 32'(Cout), 32'h0);
    chk("rst.Ovf", 32'(Overflow), 32'h0);
    @(negedge Clk);
    Rst_n = 1'b1;

    // Directed table; each entry also checks that Done is a single-cycle pulse.
    foreach (vecs[i]) begin
      run_and_check($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub,
                    vecs[i].s, vecs[i].cout, vecs[i].ovf);
      @(posedge Clk); #1;
      chk($sformatf("vec%0d.donepulse", i), 32'(Done), 32'h0);
      chk($sformatf("vec%0d.idle", i), 32'(Busy), 32'h0);
      chk($sformatf("vec%0d.Shold", i), 32'(S), 32'(vecs[i].s));
    end

    // Back-to-back: the second Start is driven during the DONE cycle.
    run_and_check("b2b1", 16'h1234, 16'h1111, 1'b1, 1'b0, 16'h2346, 1'b0, 1'b0);
    run_and_check("b2b2", 16'hAAAA, 16'h5555, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b0);
    @(posedge Clk); #1;

    // Start and new operands during RUN cycle 2 must be ignored.
    @(negedge Clk);
    A = 16'h0102; B = 16'h0304; Cin = 1'b0; Sub = 1'b0; Start = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
    @(posedge Clk); #1;
    Start = 1'b1; A = 16'hFFFF; B = 16'hFFFF; Cin = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
    dcnt  = 0;
    sdone = '0;
    for (int k = 0; k < 10; k++) begin
      if (Done) begin
        dcnt++;
        sdone = S;
      end
      @(posedge Clk); #1;
    end
    chk("busyprot.dones", 32'(dcnt), 32'd1);
    chk("busyprot.S", 32'(sdone), 32'h0406);

    // Reset in RUN cycle 2 abandons the operation.
    @(negedge Clk);
    A = 16'h1111; B = 16'h2222; Cin = 1'b0; Start = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
    @(posedge Clk); #1;
    Rst_n = 1'b0;
    #1;
    chk("midrst.S", 32'(S), 32'h0);
    chk("midrst.Busy", 32'(Busy), 32'h0);
    chk("midrst.Done", 32'(Done), 32'h0);
    @(negedge Clk);
    @(negedge Clk);
    Rst_n = 1'b1;
    dcnt = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge Clk); #1;
      if (Done) dcnt++;
    end
    chk("midrst.nodone", 32'(dcnt), 32'd0);
    run_and_check("postrst", 16'h0003, 16'h0004, 1'b0, 1'b0, 16'h0007, 1'b0, 1'b0);
    @(posedge Clk); #1;

    // Randomized operations against the reference model.
    for (int r = 0; r < 40; r++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
`ifdef NIBBLE_ADD_SUB_EN
      rs = 1'($urandom);
`else
      rs = 1'b0;
`endif
      if (r % 8 == 0) ra = '1;
      model(ra, rb, rc, rs, es, ec, eo);
      run_and_check($sformatf("rnd%0d", r), ra, rb, rc, rs, es, ec, eo);
      if (r % 3 == 0) begin
        @(posedge Clk); #1;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
